// File: rtl/ram_march_tester.sv
// ram_march_tester: march BIST controller for a single-port RAM.
// Runs W0 (write PATTERN, up), R0 (read PATTERN, up), W1 (write ~PATTERN, down) and
// R1 (read ~PATTERN, down), then drains outstanding compares. It reports pass/fail
// and the address/data of the first mismatch.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start                        level-sampled test request (accepted in IDLE/DONE)
//   busy, done, pass, fail       status (pass/fail valid while done)
//   fail_addr, fail_data         first mismatch address / read data
//   mem_en, mem_r, mem_addr,
//   mem_data                     RAM request (registered, one access per cycle)
//   mem_out                      RAM read data, valid RD_LAT cycles after the read
module ram_march_tester #(
  parameter int unsigned       ADDR_W  = 6,
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'h55),
  parameter int unsigned       RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int unsigned       LAST     = RD_LAT - 1;
  localparam int unsigned       CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_W0, S_R0, S_W1, S_R1, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_r_q, mem_r_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;

  // Compare pipeline: stage 0 captures the read driven this cycle, the last stage
  // lines up with its data on mem_out.
  logic                pipe_vld_q  [RD_LAT];
  logic [DATA_W-1:0]   pipe_exp_q  [RD_LAT];
  logic [ADDR_W-1:0]   pipe_addr_q [RD_LAT];

  logic                mismatch_c;

  assign mismatch_c = pipe_vld_q[LAST] && (mem_out != pipe_exp_q[LAST]);

  // Next-state: each state value names the phase of the access being driven now.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    mem_en_d    = 1'b0;
    mem_r_d     = 1'b1;
    mem_addr_d  = '0;
    mem_data_d  = '0;
    exp_d       = '0;
    drain_cnt_d = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_W0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          mem_en_d    = 1'b1;
          mem_r_d     = 1'b0;
          mem_data_d  = PATTERN;
        end
      end
      S_W0: begin
        mem_en_d = 1'b1;
        if (mem_addr_q == ADDR_MAX) begin
          state_d = S_R0;
          exp_d   = PATTERN;
        end else begin
          mem_r_d    = 1'b0;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          mem_data_d = PATTERN;
        end
      end
      S_R0: begin
        mem_en_d = 1'b1;
        if (mem_addr_q == ADDR_MAX) begin
          state_d    = S_W1;
          mem_r_d    = 1'b0;
          mem_addr_d = ADDR_MAX;
          mem_data_d = ~PATTERN;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          exp_d      = PATTERN;
        end
      end
      S_W1: begin
        mem_en_d = 1'b1;
        if (mem_addr_q == '0) begin
          state_d    = S_R1;
          mem_addr_d = ADDR_MAX;
          exp_d      = ~PATTERN;
        end else begin
          mem_r_d    = 1'b0;
          mem_addr_d = mem_addr_q - ADDR_W'(1);
          mem_data_d = ~PATTERN;
        end
      end
      S_R1: begin
        if (mem_addr_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr_q - ADDR_W'(1);
          exp_d      = ~PATTERN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == CNT_W'(LAST)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // First mismatch wins over everything: stop issuing and report.
    if (mismatch_c) begin
      state_d     = S_DONE;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      pass_d      = 1'b0;
      fail_d      = 1'b1;
      fail_addr_d = pipe_addr_q[LAST];
      fail_data_d = mem_out;
      mem_en_d    = 1'b0;
      mem_r_d     = 1'b1;
      mem_addr_d  = '0;
      mem_data_d  = '0;
      exp_d       = '0;
      drain_cnt_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      mem_en_q    <= 1'b0;
      mem_r_q     <= 1'b1;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      exp_q       <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      mem_en_q    <= mem_en_d;
      mem_r_q     <= mem_r_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      exp_q       <= exp_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Compare pipeline; a mismatch discards everything still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_exp_q[i]  <= '0;
        pipe_addr_q[i] <= '0;
      end
    end else if (mismatch_c) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
      end
    end else begin
      pipe_vld_q[0]  <= mem_en_q & mem_r_q;
      pipe_exp_q[0]  <= exp_q;
      pipe_addr_q[0] <= mem_addr_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_exp_q[i]  <= pipe_exp_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign mem_en    = mem_en_q;
  assign mem_r     = mem_r_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: two instances (RD_LAT=1 and RD_LAT=2), each on its
// own behavioural RAM with an optional stuck-at cell. An index-based march model
// predicts every cycle's access and the final verdict.
module tb_ram_march_tester;

  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 8;
  localparam int          N   = 64;
  localparam logic [7:0]  PAT = 8'h55;
  localparam int          M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          start_r     [2];
  logic          busy_w      [2];
  logic          done_w      [2];
  logic          pass_w      [2];
  logic          fail_w      [2];
  logic          mem_r_w     [2];
  logic          mem_en_w    [2];
  logic [AW-1:0] fail_addr_w [2];
  logic [AW-1:0] mem_addr_w  [2];
  logic [DW-1:0] fail_data_w [2];
  logic [DW-1:0] mem_data_w  [2];
  logic [DW-1:0] mem_out_w   [2];

  ram_march_tester #(.RD_LAT(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_r[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]),
    .fail_addr(fail_addr_w[0]), .fail_data(fail_data_w[0]),
    .mem_data(mem_data_w[0]), .mem_addr(mem_addr_w[0]), .mem_r(mem_r_w[0]),
    .mem_en(mem_en_w[0]), .mem_out(mem_out_w[0])
  );

  ram_march_tester #(.RD_LAT(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_r[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]),
    .fail_addr(fail_addr_w[1]), .fail_data(fail_data_w[1]),
    .mem_data(mem_data_w[1]), .mem_addr(mem_addr_w[1]), .mem_r(mem_r_w[1]),
    .mem_en(mem_en_w[1]), .mem_out(mem_out_w[1])
  );

  // Fault configuration per RAM: one cell bit stuck at f_val.
  logic          f_en   [2];
  logic [AW-1:0] f_addr [2];
  int            f_bit  [2];
  logic          f_val  [2];

  function automatic logic [7:0] faulty(input int d, input logic [AW-1:0] a, input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (f_en[d] && a == f_addr[d]) r[f_bit[d]] = f_val[d];
    return r;
  endfunction

  // Behavioural RAMs: registered read, second stage for the RD_LAT=2 instance.
  logic [7:0] ram [2][N];
  logic [7:0] rq1 [2];
  logic [7:0] rq2 [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en_w[d]) begin
        if (!mem_r_w[d]) ram[d][mem_addr_w[d]] <= mem_data_w[d];
        else             rq1[d] <= faulty(d, mem_addr_w[d], ram[d][mem_addr_w[d]]);
      end
      rq2[d] <= rq1[d];
    end
  end

  assign mem_out_w[0] = rq1[0];
  assign mem_out_w[1] = rq2[1];

  // March sequence by access index k = 0..4N-1.
  function automatic logic [AW-1:0] acc_addr(input int k);
    int ph, i;
    ph = k / N;
    i  = k % N;
    return (ph < 2) ? AW'(i) : AW'(N - 1 - i);
  endfunction

  function automatic logic acc_rd(input int k);
    return ((k / N) % 2) == 1;
  endfunction

  function automatic logic [7:0] acc_data(input int k);
    return ((k / N) < 2) ? PAT : ~PAT;
  endfunction

  // Model state per instance.
  int            lat      [2] = '{1, 2};
  int            mstate   [2];
  int            cyc      [2];
  int            done_cyc [2];
  int            last_acc [2];
  logic          e_pass   [2];
  logic [AW-1:0] e_faddr  [2];
  logic [7:0]    e_fdata  [2];
  int            bcnt     [2];
  int            prev_st;

  int n_checks = 0;
  int n_err    = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t got=%0h exp=%0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic predict(input int d);
    logic [7:0] rb;
    e_pass[d]   = 1'b1;
    e_faddr[d]  = '0;
    e_fdata[d]  = '0;
    last_acc[d] = 4 * N;
    done_cyc[d] = 4 * N + lat[d] + 1;
    for (int k = 0; k < 4 * N; k++) begin
      if (acc_rd(k)) begin
        rb = faulty(d, acc_addr(k), acc_data(k));
        if (rb != acc_data(k)) begin
          e_pass[d]   = 1'b0;
          e_faddr[d]  = acc_addr(k);
          e_fdata[d]  = rb;
          last_acc[d] = (k + 1 + lat[d] < 4 * N) ? k + 1 + lat[d] : 4 * N;
          done_cyc[d] = k + 1 + lat[d] + 1;
          break;
        end
      end
    end
  endtask

  // Model timeline: cycle 1 is the cycle after the accepting edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        mstate[d] = M_IDLE;
        cyc[d]    = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        prev_st = mstate[d];
        if (prev_st == M_RUN) begin
          cyc[d]++;
          if (cyc[d] == done_cyc[d]) mstate[d] = M_DONE;
        end
        if (prev_st != M_RUN && start_r[d]) begin
          mstate[d] = M_RUN;
          cyc[d]    = 1;
          predict(d);
        end
      end
    end
  end

  // Compare process: every cycle, both instances, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (busy_w[d]) bcnt[d]++;
      if (chk_en) begin
        case (mstate[d])
          M_RUN: begin
            chk("busy_run", d, 32'(busy_w[d]), 32'h1);
            chk("done_run", d, 32'(done_w[d]), 32'h0);
            chk("pass_run", d, 32'(pass_w[d]), 32'h0);
            chk("fail_run", d, 32'(fail_w[d]), 32'h0);
            chk("faddr_run", d, 32'(fail_addr_w[d]), 32'h0);
            if (cyc[d] <= last_acc[d]) begin
              chk("mem_en", d, 32'(mem_en_w[d]), 32'h1);
              chk("mem_r", d, 32'(mem_r_w[d]), 32'(acc_rd(cyc[d] - 1)));
              chk("mem_addr", d, 32'(mem_addr_w[d]), 32'(acc_addr(cyc[d] - 1)));
              chk("mem_data", d, 32'(mem_data_w[d]),
                  acc_rd(cyc[d] - 1) ? 32'h0 : 32'(acc_data(cyc[d] - 1)));
            end else begin
              chk("mem_en_drain", d, 32'(mem_en_w[d]), 32'h0);
              chk("mem_r_drain", d, 32'(mem_r_w[d]), 32'h1);
            end
          end
          M_DONE: begin
            chk("busy_done", d, 32'(busy_w[d]), 32'h0);
            chk("done", d, 32'(done_w[d]), 32'h1);
            chk("pass", d, 32'(pass_w[d]), 32'(e_pass[d]));
            chk("fail", d, 32'(fail_w[d]), 32'(!e_pass[d]));
            if (!e_pass[d]) begin
              chk("fail_addr", d, 32'(fail_addr_w[d]), 32'(e_faddr[d]));
              chk("fail_data", d, 32'(fail_data_w[d]), 32'(e_fdata[d]));
            end
            chk("mem_en_done", d, 32'(mem_en_w[d]), 32'h0);
            chk("mem_r_done", d, 32'(mem_r_w[d]), 32'h1);
          end
          default: begin
            chk("busy_idle", d, 32'(busy_w[d]), 32'h0);
            chk("done_idle", d, 32'(done_w[d]), 32'h0);
            chk("pass_idle", d, 32'(pass_w[d]), 32'h0);
            chk("fail_idle", d, 32'(fail_w[d]), 32'h0);
            chk("faddr_idle", d, 32'(fail_addr_w[d]), 32'h0);
            chk("fdata_idle", d, 32'(fail_data_w[d]), 32'h0);
            chk("mem_en_idle", d, 32'(mem_en_w[d]), 32'h0);
            chk("mem_r_idle", d, 32'(mem_r_w[d]), 32'h1);
            chk("mem_addr_idle", d, 32'(mem_addr_w[d]), 32'h0);
            chk("mem_data_idle", d, 32'(mem_data_w[d]), 32'h0);
          end
        endcase
      end
    end
  end

  task automatic set_fault(input int d, input logic en, input logic [AW-1:0] a, input int b, input logic v);
    f_en[d]   = en;
    f_addr[d] = a;
    f_bit[d]  = b;
    f_val[d]  = v;
  endtask

  // Start a run holding start for 'hold' edges, then wait (bounded) for done.
  task automatic do_run(input int d, input int hold, input logic chk_clear);
    int t;
    @(posedge clk); #2;
    bcnt[d]    = 0;
    start_r[d] = 1'b1;
    repeat (hold) @(posedge clk);
    #2;
    if (chk_clear) begin
      chk("pass_cleared_on_accept", d, 32'(pass_w[d]), 32'h0);
      chk("busy_on_accept", d, 32'(busy_w[d]), 32'h1);
    end
    start_r[d] = 1'b0;
    t = 0;
    while (!done_w[d] && t < 700) begin
      @(negedge clk);
      t++;
    end
    if (!done_w[d]) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout_done dut%0d got=no_done exp=done", d);
    end
  endtask

  initial begin
    int t;
    reset_n    = 1'b1;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    set_fault(0, 1'b0, '0, 0, 1'b0);
    set_fault(1, 1'b0, '0, 0, 1'b0);
    bcnt[0] = 0;
    bcnt[1] = 0;
    #1 reset_n = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("reset_mem_r", 0, 32'(mem_r_w[0]), 32'h1);
    chk("reset_mem_en", 1, 32'(mem_en_w[1]), 32'h0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Fault-free run, RD_LAT=1.
    do_run(0, 1, 1'b0);
    chk("busy_cycles_pass", 0, 32'(bcnt[0]), 32'd257);
    chk("pass_lit", 0, 32'(pass_w[0]), 32'h1);

    // addr 0x2A bit0 stuck-at-0: caught in R0.
    set_fault(0, 1'b1, 6'h2A, 0, 1'b0);
    do_run(0, 1, 1'b0);
    chk("fail_lit", 0, 32'(fail_w[0]), 32'h1);
    chk("fail_addr_2a", 0, 32'(fail_addr_w[0]), 32'h2A);
    chk("fail_data_54", 0, 32'(fail_data_w[0]), 32'h54);
    chk("busy_cycles_2a", 0, 32'(bcnt[0]), 32'd108);

    // addr 0x05 bit0 stuck-at-1: R0 passes, R1 fails.
    set_fault(0, 1'b1, 6'h05, 0, 1'b1);
    do_run(0, 1, 1'b0);
    chk("fail_addr_05", 0, 32'(fail_addr_w[0]), 32'h05);
    chk("fail_data_ab", 0, 32'(fail_data_w[0]), 32'hAB);
    chk("busy_cycles_05", 0, 32'(bcnt[0]), 32'd252);

    // Passing run, then restart from DONE.
    set_fault(0, 1'b0, '0, 0, 1'b0);
    do_run(0, 1, 1'b0);
    chk("pass_before_restart", 0, 32'(pass_w[0]), 32'h1);
    do_run(0, 1, 1'b1);
    chk("pass_after_restart", 0, 32'(pass_w[0]), 32'h1);
    chk("busy_cycles_restart", 0, 32'(bcnt[0]), 32'd257);

    // start held high for most of the run is ignored while busy.
    do_run(0, 200, 1'b0);
    chk("busy_cycles_held", 0, 32'(bcnt[0]), 32'd257);
    chk("pass_held", 0, 32'(pass_w[0]), 32'h1);

    // Async reset while R0 is at address 0x10.
    @(posedge clk); #2 start_r[0] = 1'b1;
    @(posedge clk); #2 start_r[0] = 1'b0;
    t = 0;
    while (!(mem_en_w[0] && mem_r_w[0] && mem_addr_w[0] == 6'h10) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("r0_addr10_cycle", 0, 32'(t), 32'd81);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 0, 32'(busy_w[0]), 32'h0);
    chk("rst_mid_mem_en", 0, 32'(mem_en_w[0]), 32'h0);
    chk("rst_mid_mem_r", 0, 32'(mem_r_w[0]), 32'h1);
    chk("rst_mid_mem_addr", 0, 32'(mem_addr_w[0]), 32'h0);
    chk("rst_mid_done", 0, 32'(done_w[0]), 32'h0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    do_run(0, 1, 1'b0);
    chk("busy_cycles_after_rst", 0, 32'(bcnt[0]), 32'd257);
    chk("pass_after_rst", 0, 32'(pass_w[0]), 32'h1);

    // RD_LAT=2: fault-free, then addr 0x3F bit7 stuck-at-1.
    do_run(1, 1, 1'b0);
    chk("busy_cycles_lat2", 1, 32'(bcnt[1]), 32'd258);
    chk("pass_lat2", 1, 32'(pass_w[1]), 32'h1);
    set_fault(1, 1'b1, 6'h3F, 7, 1'b1);
    do_run(1, 1, 1'b0);
    chk("fail_addr_3f", 1, 32'(fail_addr_w[1]), 32'h3F);
    chk("fail_data_d5", 1, 32'(fail_data_w[1]), 32'hD5);
    chk("busy_cycles_3f", 1, 32'(bcnt[1]), 32'd130);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
